// File: rtl/uart_rx_word_assembler.sv
// Receive-side word framer: packs consecutive UART bytes MSB-first into a word,
// offers it on a valid/ack handshake and drops partial words after line silence.
module uart_rx_word_assembler #(
   parameter int DBITS         = 8,
   parameter int WORD_BYTES    = 4,
   parameter int TIMEOUT_TICKS = 320,
   parameter int TIMEOUT_BITS  = 9
) (
   input  logic                          clk_100MHz,
   input  logic                          reset,
   input  logic                          sample_tick,
   input  logic                          rx_data_ready,
   input  logic [DBITS-1:0]              rx_data_in,
   output logic [DBITS*WORD_BYTES-1:0]   word_out,
   output logic                          word_valid,
   input  logic                          word_ack,
   output logic [$clog2(WORD_BYTES):0]   byte_count,
   output logic                          timeout_err,
   output logic                          overrun
);

   localparam int WORD_W = DBITS * WORD_BYTES;
   localparam int ASM_W  = DBITS * (WORD_BYTES - 1);
   localparam int BC_W   = $clog2(WORD_BYTES) + 1;
   localparam logic [BC_W-1:0]         BC_LAST = BC_W'(WORD_BYTES - 1);
   localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT_TICKS - 1);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                  state, state_n;
   // Only the bytes preceding the final one need storing; the last byte is
   // taken straight from rx_data_in when the word completes.
   logic [ASM_W-1:0]        asm_q, asm_n;
   logic [TIMEOUT_BITS-1:0] to_cnt, to_cnt_n;
   logic [WORD_W-1:0]       word_n;
   logic                    valid_n, terr_n, ovr_n;
   logic [BC_W-1:0]         bc_n;
   logic                    ack_ok;

   assign ack_ok = word_ack & word_valid;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         asm_q       <= '0;
         to_cnt      <= '0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         byte_count  <= '0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         asm_q       <= asm_n;
         to_cnt      <= to_cnt_n;
         word_out    <= word_n;
         word_valid  <= valid_n;
         byte_count  <= bc_n;
         timeout_err <= terr_n;
         overrun     <= ovr_n;
      end
   end

   always_comb begin
      state_n  = state;
      asm_n    = asm_q;
      to_cnt_n = to_cnt;
      word_n   = word_out;
      valid_n  = word_valid;
      bc_n     = byte_count;
      terr_n   = 1'b0;
      ovr_n    = overrun;

      if (ack_ok) begin
         valid_n = 1'b0;
         ovr_n   = 1'b0;
      end

      case (state)
         IDLE: begin
            if (rx_data_ready) begin
               asm_n    = {asm_q[ASM_W-DBITS-1:0], rx_data_in};
               bc_n     = BC_W'(1);
               to_cnt_n = '0;
               state_n  = COLLECT;
            end
         end
         COLLECT: begin
            // A byte arriving with the final tick wins over the timeout.
            if (rx_data_ready) begin
               to_cnt_n = '0;
               if (byte_count == BC_LAST) begin
                  bc_n    = '0;
                  state_n = IDLE;
                  if (!word_valid || word_ack) begin
                     word_n  = {asm_q, rx_data_in};
                     valid_n = 1'b1;
                  end else begin
                     ovr_n = 1'b1;
                  end
               end else begin
                  asm_n = {asm_q[ASM_W-DBITS-1:0], rx_data_in};
                  bc_n  = byte_count + BC_W'(1);
               end
            end else if (sample_tick) begin
               if (to_cnt == TO_LAST) begin
                  to_cnt_n = '0;
                  bc_n     = '0;
                  terr_n   = 1'b1;
                  state_n  = IDLE;
               end else begin
                  to_cnt_n = to_cnt + TIMEOUT_BITS'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler: a vector table for the handshake
// paths plus hand sequences for timeout, timeout race and asynchronous reset.
module tb_uart_rx_word_assembler;

   logic        clk_100MHz = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        rx_data_ready = 1'b0;
   logic [7:0]  rx_data_in = 8'h00;
   logic        word_ack = 1'b0;
   logic [31:0] word_out;
   logic        word_valid;
   logic [2:0]  byte_count;
   logic        timeout_err;
   logic        overrun;

   int errors = 0;
   int checks = 0;
   int terr_seen = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   uart_rx_word_assembler #(
      .DBITS(8), .WORD_BYTES(4), .TIMEOUT_TICKS(320), .TIMEOUT_BITS(9)
   ) dut (
      .clk_100MHz   (clk_100MHz),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .rx_data_ready(rx_data_ready),
      .rx_data_in   (rx_data_in),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ack     (word_ack),
      .byte_count   (byte_count),
      .timeout_err  (timeout_err),
      .overrun      (overrun)
   );

   typedef struct {
      logic        rdy;
      logic [7:0]  data;
      logic        ack;
      logic [31:0] exp_word;
      logic        exp_valid;
      logic [2:0]  exp_bc;
      logic        exp_ovr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rdy, input logic [7:0] data, input logic ack,
                               input logic [31:0] w, input logic vld, input logic [2:0] bc,
                               input logic ovr);
      vec_t v;
      v.rdy = rdy; v.data = data; v.ack = ack;
      v.exp_word = w; v.exp_valid = vld; v.exp_bc = bc; v.exp_ovr = ovr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_100MHz);
      #1;
      if (timeout_err === 1'b1) terr_seen++;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data_ready = 1'b1;
      rx_data_in    = b;
      cyc();
      rx_data_ready = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sample_tick = 1'b1;
         cyc();
         sample_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_word"},  word_out, 32'h0);
      chk({tag, "_valid"}, {31'b0, word_valid}, 32'h0);
      chk({tag, "_bc"},    {29'b0, byte_count}, 32'h0);
      chk({tag, "_terr"},  {31'b0, timeout_err}, 32'h0);
      chk({tag, "_ovr"},   {31'b0, overrun}, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      // Basic word with gaps and a delayed ack
      tbl.push_back(mk(1, 8'hDE, 0, 32'h0, 0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 1, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 1, 0));
      tbl.push_back(mk(1, 8'hAD, 0, 32'h0, 0, 2, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 2, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 2, 0));
      tbl.push_back(mk(1, 8'hBE, 0, 32'h0, 0, 3, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 3, 0));
      tbl.push_back(mk(0, 8'h00, 0, 32'h0, 0, 3, 0));
      tbl.push_back(mk(1, 8'hEF, 0, 32'hDEADBEEF, 1, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'h00, 0, 32'hDEADBEEF, 1, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 32'hDEADBEEF, 0, 0, 0));
      // Overrun: second word completes with the first still pending
      tbl.push_back(mk(1, 8'h01, 0, 32'hDEADBEEF, 0, 1, 0));
      tbl.push_back(mk(1, 8'h02, 0, 32'hDEADBEEF, 0, 2, 0));
      tbl.push_back(mk(1, 8'h03, 0, 32'hDEADBEEF, 0, 3, 0));
      tbl.push_back(mk(1, 8'h04, 0, 32'h01020304, 1, 0, 0));
      tbl.push_back(mk(1, 8'h05, 0, 32'h01020304, 1, 1, 0));
      tbl.push_back(mk(1, 8'h06, 0, 32'h01020304, 1, 2, 0));
      tbl.push_back(mk(1, 8'h07, 0, 32'h01020304, 1, 3, 0));
      tbl.push_back(mk(1, 8'h08, 0, 32'h01020304, 1, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 32'h01020304, 1, 0, 1));
      tbl.push_back(mk(0, 8'h00, 1, 32'h01020304, 0, 0, 0));
      // Ack colliding with the completing byte
      tbl.push_back(mk(1, 8'h12, 0, 32'h01020304, 0, 1, 0));
      tbl.push_back(mk(1, 8'h34, 0, 32'h01020304, 0, 2, 0));
      tbl.push_back(mk(1, 8'h56, 0, 32'h01020304, 0, 3, 0));
      tbl.push_back(mk(1, 8'h78, 0, 32'h12345678, 1, 0, 0));
      tbl.push_back(mk(1, 8'hCA, 0, 32'h12345678, 1, 1, 0));
      tbl.push_back(mk(1, 8'hFE, 0, 32'h12345678, 1, 2, 0));
      tbl.push_back(mk(1, 8'hF0, 0, 32'h12345678, 1, 3, 0));
      tbl.push_back(mk(1, 8'h0D, 1, 32'hCAFEF00D, 1, 0, 0));
      // Drop sets overrun; a later ack+completion loads and clears it
      tbl.push_back(mk(1, 8'h9A, 0, 32'hCAFEF00D, 1, 1, 0));
      tbl.push_back(mk(1, 8'hBC, 0, 32'hCAFEF00D, 1, 2, 0));
      tbl.push_back(mk(1, 8'hDE, 0, 32'hCAFEF00D, 1, 3, 0));
      tbl.push_back(mk(1, 8'hF0, 0, 32'hCAFEF00D, 1, 0, 1));
      tbl.push_back(mk(1, 8'h11, 0, 32'hCAFEF00D, 1, 1, 1));
      tbl.push_back(mk(1, 8'h22, 0, 32'hCAFEF00D, 1, 2, 1));
      tbl.push_back(mk(1, 8'h33, 0, 32'hCAFEF00D, 1, 3, 1));
      tbl.push_back(mk(1, 8'h44, 1, 32'h11223344, 1, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 32'h11223344, 0, 0, 0));

      // Reset state
      cyc();
      chk_zero("rst_init");
      cyc();
      reset = 1'b0;

      foreach (tbl[i]) begin
         rx_data_ready = tbl[i].rdy;
         rx_data_in    = tbl[i].data;
         word_ack      = tbl[i].ack;
         cyc();
         chk($sformatf("v%0d_word", i),  word_out, tbl[i].exp_word);
         chk($sformatf("v%0d_valid", i), {31'b0, word_valid}, {31'b0, tbl[i].exp_valid});
         chk($sformatf("v%0d_bc", i),    {29'b0, byte_count}, {29'b0, tbl[i].exp_bc});
         chk($sformatf("v%0d_ovr", i),   {31'b0, overrun}, {31'b0, tbl[i].exp_ovr});
         chk($sformatf("v%0d_terr", i),  {31'b0, timeout_err}, 32'h0);
      end
      rx_data_ready = 1'b0;
      word_ack      = 1'b0;

      // Timeout realign
      do_reset();
      send(8'h11);
      send(8'h22);
      chk("to_bc2", {29'b0, byte_count}, 32'd2);
      terr_seen = 0;
      ticks(319);
      chk("to_pre_pulses", terr_seen, 0);
      chk("to_pre_bc", {29'b0, byte_count}, 32'd2);
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      chk("to_terr", {31'b0, timeout_err}, 32'd1);
      chk("to_bc0", {29'b0, byte_count}, 32'd0);
      cyc();
      chk("to_terr_width", {31'b0, timeout_err}, 32'd0);
      send(8'hA1);
      send(8'hB2);
      send(8'hC3);
      send(8'hD4);
      chk("to_word", word_out, 32'hA1B2C3D4);
      chk("to_valid", {31'b0, word_valid}, 32'd1);
      chk("to_pulses", terr_seen, 1);
      word_ack = 1'b1;
      cyc();
      word_ack = 1'b0;
      chk("to_ack", {31'b0, word_valid}, 32'd0);

      // No counting in IDLE
      terr_seen = 0;
      ticks(330);
      chk("idle_no_to", terr_seen, 0);

      // Timeout race: byte coincides with the 320th tick
      send(8'h55);
      ticks(319);
      sample_tick   = 1'b1;
      rx_data_ready = 1'b1;
      rx_data_in    = 8'h66;
      cyc();
      sample_tick   = 1'b0;
      rx_data_ready = 1'b0;
      chk("race_terr", {31'b0, timeout_err}, 32'd0);
      chk("race_bc", {29'b0, byte_count}, 32'd2);
      cyc();
      chk("race_terr2", {31'b0, timeout_err}, 32'd0);
      ticks(319);
      chk("race_restart", terr_seen, 0);
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      chk("race_full_to", {31'b0, timeout_err}, 32'd1);
      chk("race_full_bc", {29'b0, byte_count}, 32'd0);

      // Reset mid-word with a word pending
      send(8'hF1);
      send(8'hF2);
      send(8'hF3);
      send(8'hF4);
      chk("rm_pending", {31'b0, word_valid}, 32'd1);
      send(8'h77);
      send(8'h88);
      chk("rm_bc2", {29'b0, byte_count}, 32'd2);
      #3;
      reset = 1'b1;
      #1;
      chk_zero("rm_async");
      cyc();
      chk_zero("rm_hold1");
      cyc();
      chk_zero("rm_hold2");
      reset = 1'b0;
      terr_seen = 0;
      send(8'h01);
      chk("rm_bc1", {29'b0, byte_count}, 32'd1);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      chk("rm_word", word_out, 32'h01020304);
      chk("rm_valid", {31'b0, word_valid}, 32'd1);
      chk("rm_no_terr", terr_seen, 0);
      chk("rm_ovr", {31'b0, overrun}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

Receive-side word framer that sits between the UART receiver (`data_ready`/`data_out`) and user logic. It is the reading counterpart of the transmit path's 4-byte batch send. It collects consecutive received bytes into a WORD_BYTES-wide word, most significant byte first, and presents the word with a valid/ack handshake. An inter-byte timeout, counted in baud-generator sample ticks, discards partial words so the framer re-aligns after line noise or a dropped byte.

## Interface
- DBITS, 8, bits per received byte
- WORD_BYTES, 4, bytes per assembled word (≥2)
- TIMEOUT_TICKS, 320, sample ticks of line silence that abort a partial word (320 ticks = 2 character times at 16x oversampling)
- TIMEOUT_BITS, 9, width of the timeout counter (must hold TIMEOUT_TICKS)

Ports:
- clk_100MHz  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle 16x oversample tick from baud_rate_generator
- rx_data_ready  in  1  one-cycle strobe: rx_data_in holds a new byte
- rx_data_in  in  DBITS  received byte
- word_out  out  DBITS*WORD_BYTES  assembled word; first byte in bits [top:top-DBITS+1]
- word_valid  out  1  word_out holds an unconsumed word
- word_ack  in  1  consumer accepts word_out (only meaningful while word_valid=1)
- byte_count  out  clog2(WORD_BYTES)+1  bytes currently held in the partial word
- timeout_err  out  1  one-cycle pulse when a partial word is discarded
- overrun  out  1  sticky: a completed word was dropped because word_valid was still set

## Operation
- Datapath: an internal assembly shift register `asm`, plus a separate output register `word_out`, so assembly continues while a word is pending.
- States: IDLE (byte_count=0) and COLLECT (1 ≤ byte_count ≤ WORD_BYTES-1).
- IDLE + rx_data_ready: `asm` ← {asm[rest], rx_data_in}; byte_count=1; timeout counter cleared; go to COLLECT.
- COLLECT + rx_data_ready, byte_count < WORD_BYTES-1: shift the byte in, byte_count+1, clear the timeout counter.
- COLLECT + rx_data_ready, byte_count = WORD_BYTES-1 (word completes): the full word {asm[lower bytes], rx_data_in} is presented; byte_count ← 0; go to IDLE.
  - If word_valid=0, or word_ack=1 in the same cycle: word_out ← full word, word_valid ← 1.
  - Otherwise: the new word is dropped, word_out is unchanged, and overrun ← 1.
- Timeout: in COLLECT, each sample_tick increments the timeout counter. When the count reaches TIMEOUT_TICKS: byte_count ← 0, state ← IDLE, timeout_err pulses for 1 cycle. `asm` contents are don't-care.
  - No counting occurs in IDLE.
- rx_data_ready and the timeout-reaching sample_tick in the same cycle: the byte wins. It is accepted, the counter is cleared, and no timeout_err is raised.
- word_ack with word_valid=1 and no completing word: word_valid ← 0; word_out holds its last value.
- word_ack with word_valid=0: ignored.
- overrun clears on the cycle word_ack is accepted, or on reset. If an ack and a new drop would coincide, the ack loads the new word instead (see above), so there is no drop.
- Arithmetic: the timeout counter is unsigned TIMEOUT_BITS and saturates by construction, since it is cleared at TIMEOUT_TICKS. byte_count never exceeds WORD_BYTES-1.

## Timing
- Reset (asynchronous, immediate): word_out=0, word_valid=0, byte_count=0, timeout_err=0, overrun=0, asm=0, timeout counter=0, state IDLE.
- Reset asserted mid-word or while a word is pending: everything is lost and the block returns to reset values. The first byte after deassertion starts a new word.
- Latency: word_valid rises on the clock edge that samples the final rx_data_ready, so it is visible 1 cycle after the strobe.
- word_valid falls on the edge that samples word_ack=1.
- Back-to-back: rx_data_ready may assert on consecutive cycles. Every strobe is accepted; there is no backpressure to the receiver.
- timeout_err is registered. It is high for exactly the cycle after the terminating sample_tick.
- byte_count is registered and updates on the same edge as the byte strobe.

## Test plan
- Basic word: bytes 0xDE, 0xAD, 0xBE, 0xEF with 3-cycle gaps, ack 5 cycles after valid -> word_out=0xDEADBEEF, word_valid high from 1 cycle after the 4th strobe until 1 cycle after ack; overrun=0.
- Timeout realign: send 0x11, 0x22, then silence for 320 sample_ticks, then 0xA1, 0xB2, 0xC3, 0xD4 -> one timeout_err pulse after tick 320; word_out=0xA1B2C3D4; no word containing 0x11 ever appears.
- Timeout race: after 0x55, deliver 319 ticks, then assert the 320th tick together with byte 0x66 -> no timeout_err; byte_count=2.
- Overrun: complete 0x01020304, no ack, then complete 0x05060708 -> word_out stays 0x01020304 and overrun=1. Ack -> word_valid=0, overrun=0.
- Ack/complete collision: word pending, final byte strobe in the same cycle as word_ack, second word 0xCAFEF00D -> word_out=0xCAFEF00D, word_valid stays 1, overrun=0.
- Reset mid-word: after 0x77, 0x88, assert reset for 2 cycles, then send 0x01, 0x02, 0x03, 0x04 -> all outputs 0 during reset; then word_out=0x01020304 with no timeout_err.
